// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags and an iterative
// restoring divider; valid/ready on both sides, back-pressure safe.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivByZero,
    output logic             Illegal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_DIV
    } state_e;

    state_e           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] rem, rem_d;
    logic [WIDTH-1:0] quo, quo_d;
    logic [WIDTH-1:0] dvsr, dvsr_d;
    logic             is_mod, is_mod_d;
    logic [WIDTH-1:0] out_d;
    logic             carry_d, zero_d, ovf_d, dbz_d, ill_d, valid_d;

    logic             accept;
    logic             is_divmod;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] s_out;
    logic             s_carry, s_ovf, s_dbz, s_ill;

    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] rem_step, quo_step;

    always_comb begin
        in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
        busy      = (state == S_DIV);
        accept    = in_valid && in_ready;
        is_divmod = (ALU_Sel == OP_DIV) || (ALU_Sel == OP_MOD);
    end

    // Single-cycle result; div/mod here only covers the B == 0 case.
    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        prod    = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        s_out   = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        s_dbz   = 1'b0;
        s_ill   = 1'b0;
        case (ALU_Sel)
            OP_ADD: begin
                s_out   = sum[WIDTH-1:0];
                s_carry = sum[WIDTH];
            end
            OP_SUB: begin
                s_out   = A - B;
                s_carry = (A < B);
            end
            OP_MUL: begin
                s_out = prod[WIDTH-1:0];
                s_ovf = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                s_out = '1;
                s_dbz = 1'b1;
            end
            OP_MOD: begin
                s_out = A;
                s_dbz = 1'b1;
            end
            OP_AND:  s_out = A & B;
            OP_OR:   s_out = A | B;
            OP_XOR:  s_out = A ^ B;
            default: s_ill = 1'b1;
        endcase
    end

    // One restoring step: shift next dividend bit into the partial remainder.
    always_comb begin
        diff = {1'b0, rem, quo[WIDTH-1]} - {2'b00, dvsr};
        if (diff[WIDTH+1]) begin
            rem_step = {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo_step = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_step = diff[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        rem_d    = rem;
        quo_d    = quo;
        dvsr_d   = dvsr;
        is_mod_d = is_mod;
        out_d    = ALU_Out;
        carry_d  = CarryOut;
        zero_d   = Zero;
        ovf_d    = Overflow;
        dbz_d    = DivByZero;
        ill_d    = Illegal;
        valid_d  = out_valid && !out_ready;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_divmod && (B != '0)) begin
                        state_d  = S_DIV;
                        cnt_d    = CNT_W'(WIDTH - 1);
                        rem_d    = '0;
                        quo_d    = A;
                        dvsr_d   = B;
                        is_mod_d = (ALU_Sel == OP_MOD);
                    end else begin
                        out_d   = s_out;
                        carry_d = s_carry;
                        zero_d  = (s_out == '0);
                        ovf_d   = s_ovf;
                        dbz_d   = s_dbz;
                        ill_d   = s_ill;
                        valid_d = 1'b1;
                    end
                end
            end
            S_DIV: begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt == '0) begin
                    state_d = S_IDLE;
                    out_d   = is_mod ? rem_step : quo_step;
                    carry_d = 1'b0;
                    zero_d  = ((is_mod ? rem_step : quo_step) == '0);
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    ill_d   = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            is_mod    <= 1'b0;
            ALU_Out   <= '0;
            CarryOut  <= 1'b0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            DivByZero <= 1'b0;
            Illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rem       <= rem_d;
            quo       <= quo_d;
            dvsr      <= dvsr_d;
            is_mod    <= is_mod_d;
            ALU_Out   <= out_d;
            CarryOut  <= carry_d;
            Zero      <= zero_d;
            Overflow  <= ovf_d;
            DivByZero <= dbz_d;
            Illegal   <= ill_d;
            out_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized traffic
// checked against an arithmetic reference model with a result queue.
module tb_alu_seq;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] A, B;
    logic [3:0]   ALU_Sel;
    logic         in_valid, in_ready;
    logic [W-1:0] ALU_Out;
    logic         CarryOut, Zero, Overflow, DivByZero, Illegal;
    logic         out_valid, out_ready, busy;

    alu_seq #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .A(A), .B(B), .ALU_Sel(ALU_Sel),
        .in_valid(in_valid), .in_ready(in_ready), .ALU_Out(ALU_Out),
        .CarryOut(CarryOut), .Zero(Zero), .Overflow(Overflow),
        .DivByZero(DivByZero), .Illegal(Illegal), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] out;
        logic c, z, o, d, i;
        int   due;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] seen_out;
    logic         seen_c, seen_z, seen_o, seen_d, seen_i;
    int           seen_cyc = 0;
    int           acc_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
        exp_t r;
        longint unsigned ai, bi, p, m;
        ai = longint'(a);
        bi = longint'(b);
        m  = 64'd1 << W;
        r.out = '0; r.c = 1'b0; r.z = 1'b0; r.o = 1'b0; r.d = 1'b0; r.i = 1'b0; r.due = 0;
        case (s)
            4'd0: begin p = ai + bi; r.out = W'(p % m); r.c = (p >= m); end
            4'd1: begin r.out = W'((ai + m - bi) % m); r.c = (ai < bi); end
            4'd2: begin p = ai * bi; r.out = W'(p % m); r.o = ((p / m) != 0); end
            4'd3: if (bi == 0) begin r.out = W'(m - 1); r.d = 1'b1; end
                  else r.out = W'(ai / bi);
            4'd4: if (bi == 0) begin r.out = a; r.d = 1'b1; end
                  else r.out = W'(ai % bi);
            4'd5: r.out = a & b;
            4'd6: r.out = a | b;
            4'd7: r.out = a ^ b;
            default: r.i = 1'b1;
        endcase
        r.z = (r.out == '0);
        return r;
    endfunction

    // Entered at posedge+1; drives, checks the settled cycle, advances one clock.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] sel, input logic ordy, output logic acc);
        logic exp_pend, exp_ov;
        exp_t e;
        in_valid = v; A = a; B = b; ALU_Sel = sel; out_ready = ordy;
        #1;
        exp_pend = (q.size() > 0) && (cyc < q[0].due);
        exp_ov   = (q.size() > 0) && (cyc >= q[0].due);
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("busy", 32'(busy), 32'(exp_pend));
        check("in_ready", 32'(in_ready), 32'(!exp_pend && (!exp_ov || ordy)));
        if (exp_ov) begin
            check("ALU_Out", 32'(ALU_Out), 32'(q[0].out));
            check("CarryOut", 32'(CarryOut), 32'(q[0].c));
            check("Zero", 32'(Zero), 32'(q[0].z));
            check("Overflow", 32'(Overflow), 32'(q[0].o));
            check("DivByZero", 32'(DivByZero), 32'(q[0].d));
            check("Illegal", 32'(Illegal), 32'(q[0].i));
            if (ordy) begin
                seen_out = ALU_Out; seen_c = CarryOut; seen_z = Zero;
                seen_o = Overflow; seen_d = DivByZero; seen_i = Illegal;
                seen_cyc = cyc;
                void'(q.pop_front());
            end
        end
        acc = v && in_ready;
        if (acc) begin
            e = calc(a, b, sel);
            e.due = cyc + ((((sel == 4'd3) || (sel == 4'd4)) && (b != '0)) ? W + 1 : 1);
            q.push_back(e);
            acc_cyc = cyc;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                        output int lat);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin step(1'b1, a, b, s, 1'b1, acc); n++; end
        if (!acc) check("send_accept_timeout", 32'd0, 32'd1);
        n = 0;
        while (q.size() > 0 && n < 40) begin step(1'b0, a, b, s, 1'b1, acc); n++; end
        if (q.size() > 0) begin check("send_result_timeout", 32'd0, 32'd1); q.delete(); end
        lat = seen_cyc - acc_cyc;
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (q.size() > 0 && n < 40) begin step(1'b0, '0, '0, 4'd0, 1'b1, acc); n++; end
        if (q.size() > 0) begin check("drain_timeout", 32'd0, 32'd1); q.delete(); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           lat;
        logic         acc, rv, racc;
        logic [W-1:0] ra, rb;
        logic [3:0]   rs;

        reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALU_Sel = '0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ALU_Out", 32'(ALU_Out), 32'd0);
        check("rst_flags", 32'({CarryOut, Zero, Overflow, DivByZero, Illegal}), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        send(8'd200, 8'd100, 4'd0, lat);
        check("add_out", 32'(seen_out), 32'd44);
        check("add_carry", 32'(seen_c), 32'd1);
        check("add_lat", 32'(lat), 32'd1);
        send(8'd5, 8'd10, 4'd1, lat);
        check("sub_neg_out", 32'(seen_out), 32'd251);
        check("sub_neg_borrow", 32'(seen_c), 32'd1);
        send(8'd50, 8'd30, 4'd1, lat);
        check("sub_pos_out", 32'(seen_out), 32'd20);
        check("sub_pos_borrow", 32'(seen_c), 32'd0);
        send(8'd3, 8'd2, 4'd2, lat);
        check("mul_small", 32'(seen_out), 32'd6);
        check("mul_small_ovf", 32'(seen_o), 32'd0);
        send(8'd20, 8'd20, 4'd2, lat);
        check("mul_big", 32'(seen_out), 32'd144);
        check("mul_big_ovf", 32'(seen_o), 32'd1);
        send(8'hF0, 8'h3C, 4'd5, lat);
        check("and_out", 32'(seen_out), 32'h30);
        send(8'd7, 8'd9, 4'b1010, lat);
        check("illegal_flag", 32'(seen_i), 32'd1);
        check("illegal_out", 32'(seen_out), 32'd0);
        check("illegal_zero", 32'(seen_z), 32'd1);
        send(8'd30, 8'd5, 4'd3, lat);
        check("div_out", 32'(seen_out), 32'd6);
        check("div_lat", 32'(lat), 32'(W + 1));
        send(8'd30, 8'd7, 4'd4, lat);
        check("mod_out", 32'(seen_out), 32'd2);
        send(8'd7, 8'd9, 4'd3, lat);
        check("div_small_out", 32'(seen_out), 32'd0);
        check("div_small_zero", 32'(seen_z), 32'd1);
        send(8'd20, 8'd0, 4'd3, lat);
        check("div0_out", 32'(seen_out), 32'd255);
        check("div0_flag", 32'(seen_d), 32'd1);
        check("div0_lat", 32'(lat), 32'd1);
        send(8'd20, 8'd0, 4'd4, lat);
        check("mod0_out", 32'(seen_out), 32'd20);
        check("mod0_flag", 32'(seen_d), 32'd1);

        step(1'b1, 8'd10, 8'd5, 4'd0, 1'b0, acc);
        check("bp_first_accept", 32'(acc), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'd9, 8'd4, 4'd1, 1'b0, acc);
            check("bp_stalled", 32'(acc), 32'd0);
            check("bp_hold", 32'(ALU_Out), 32'd15);
        end
        step(1'b1, 8'd9, 8'd4, 4'd1, 1'b1, acc);
        check("bp_release_accept", 32'(acc), 32'd1);
        check("bp_consumed", 32'(seen_out), 32'd15);
        drain();
        check("bp_queued_out", 32'(seen_out), 32'd5);

        step(1'b1, 8'd200, 8'd3, 4'd3, 1'b1, acc);
        check("rst_div_accept", 32'(acc), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 4'd0, 1'b1, acc);
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        q.delete();
        cyc++;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ALU_Out", 32'(ALU_Out), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        send(8'd1, 8'd1, 4'd0, lat);
        check("post_rst_add", 32'(seen_out), 32'd2);

        rv = 1'b0; racc = 1'b0; ra = '0; rb = '0; rs = '0;
        for (int i = 0; i < 600; i++) begin
            if (!rv || racc) begin
                rv = ($urandom_range(0, 3) != 0);
                ra = ($urandom_range(0, 9) == 0) ? '1 : W'($urandom);
                rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
                rs = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15))
                                                 : 4'($urandom_range(0, 7));
            end
            step(rv, ra, rb, rs, ($urandom_range(0, 3) != 0), racc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
